// File: rtl/dbg_display_mux.sv
// dbg_display_mux: selectable debug-channel decimal display.
//   Picks one of N_CH packed debug channels with debounced next/prev buttons,
//   converts it to BCD with a one-bit-per-cycle double-dabble engine and drives
//   N_DIG active-low seven-segment digits with optional leading-zero blanking.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   btn_next/prev    raw active-high buttons (asynchronous to clk)
//   ch_data          channel k at [k*IN_WIDTH +: IN_WIDTH]
//   ch_sel           selected channel index
//   hex              digit d at [d*7 +: 7], bit0=a .. bit6=g, 0 = lit
//   ovf              last completed conversion needed more than N_DIG digits
//   conv_done        one-cycle pulse, aligned with the display register update
module dbg_display_mux #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned IN_WIDTH      = 6,
    parameter int unsigned N_DIG         = 4,
    parameter int unsigned DEBOUNCE      = 16,
    parameter bit          BLANK_LEADING = 1'b1,
    localparam int unsigned SEL_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       btn_next,
    input  logic                       btn_prev,
    input  logic [N_CH*IN_WIDTH-1:0]   ch_data,
    output logic [SEL_W-1:0]           ch_sel,
    output logic [N_DIG*7-1:0]         hex,
    output logic                       ovf,
    output logic                       conv_done
);

    localparam int unsigned BCD_W  = 4 * N_DIG;
    localparam int unsigned ITER_W = $clog2(IN_WIDTH + 1);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Button synchronise + debounce; index 0 = next, 1 = prev
    // ------------------------------------------------------------------
    logic [1:0]      w_btn;
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_level;
    logic [1:0]      r_pulse;
    logic [DB_W-1:0] r_db_cnt [2];

    assign w_btn = {btn_prev, btn_next};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_pulse <= '0;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                r_pulse[i] <= 1'b0;
                if (r_sync2[i] != r_level[i]) begin
                    // DEBOUNCE consecutive differing samples flip the level
                    if (r_db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
                        r_level[i]  <= ~r_level[i];
                        r_db_cnt[i] <= '0;
                        r_pulse[i]  <= ~r_level[i];
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Channel select, modulo N_CH; simultaneous pulses cancel
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] r_ch_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ch_sel <= '0;
        end else if (r_pulse[0] && !r_pulse[1]) begin
            r_ch_sel <= (r_ch_sel == SEL_W'(N_CH - 1)) ? '0 : r_ch_sel + SEL_W'(1);
        end else if (r_pulse[1] && !r_pulse[0]) begin
            r_ch_sel <= (r_ch_sel == '0) ? SEL_W'(N_CH - 1) : r_ch_sel - SEL_W'(1);
        end
    end

    // Selected channel value
    logic [IN_WIDTH-1:0] w_sel_val;

    always_comb begin
        w_sel_val = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (r_ch_sel == SEL_W'(k)) begin
                w_sel_val = ch_data[k*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Double-dabble conversion engine
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [IN_WIDTH-1:0] r_sr;
    logic [BCD_W-1:0]    r_bcd;
    logic [BCD_W-1:0]    w_bcd_adj;
    logic                r_ovf_work;
    logic [ITER_W-1:0]   r_iter;
    logic [BCD_W-1:0]    r_disp;
    logic                r_ovf;
    logic                r_conv_done;

    // Add-3 correction on every digit >= 5 ahead of the shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < int'(N_DIG); d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_LOAD;
            r_sr        <= '0;
            r_bcd       <= '0;
            r_ovf_work  <= 1'b0;
            r_iter      <= '0;
            r_disp      <= '0;
            r_ovf       <= 1'b0;
            r_conv_done <= 1'b0;
        end else begin
            r_conv_done <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    r_sr       <= w_sel_val;
                    r_bcd      <= '0;
                    r_ovf_work <= 1'b0;
                    r_iter     <= '0;
                    r_state    <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_bcd <= {w_bcd_adj[BCD_W-2:0], r_sr[IN_WIDTH-1]};
                    r_sr  <= r_sr << 1;
                    // A set top bit would be shifted out: value exceeds N_DIG digits
                    if (w_bcd_adj[BCD_W-1]) begin
                        r_ovf_work <= 1'b1;
                    end
                    if (r_iter == ITER_W'(IN_WIDTH - 1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_iter <= r_iter + ITER_W'(1);
                    end
                end
                S_DONE: begin
                    r_disp      <= r_bcd;
                    r_ovf       <= r_ovf_work;
                    r_conv_done <= 1'b1;
                    r_state     <= S_LOAD;
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Seven-segment decode with dash-on-overflow and leading-zero blanking
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] dig);
        logic [6:0] s;
        case (dig)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [N_DIG*7-1:0] w_hex;
    logic               w_zero_above;
    logic [3:0]         w_dig;

    // Walk from the top digit down, tracking whether all digits so far are zero
    always_comb begin
        w_hex        = '1;
        w_zero_above = 1'b1;
        w_dig        = '0;
        for (int d = int'(N_DIG) - 1; d >= 0; d--) begin
            w_dig        = r_disp[4*d +: 4];
            w_zero_above = w_zero_above && (w_dig == 4'd0);
            if (r_ovf) begin
                w_hex[7*d +: 7] = 7'b0111111;
            end else if (BLANK_LEADING && (d != 0) && w_zero_above) begin
                w_hex[7*d +: 7] = 7'b1111111;
            end else begin
                w_hex[7*d +: 7] = seg7(w_dig);
            end
        end
    end

    assign ch_sel    = r_ch_sel;
    assign hex       = w_hex;
    assign ovf       = r_ovf;
    assign conv_done = r_conv_done;

endmodule

// File: tb/tb_dbg_display_mux.sv
// Bench for dbg_display_mux: a default instance (A) and a 2-digit, 8-bit,
// no-blanking instance (B). Expected displays are pushed per conversion period
// and popped by a monitor on every conv_done.
module tb_dbg_display_mux;

    localparam int P_A = 8;   // IN_WIDTH 6 + 2
    localparam int P_B = 10;  // IN_WIDTH 8 + 2

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_next, btn_prev, btn_b_next, btn_b_prev;
    logic [23:0] ch_a;
    logic [15:0] ch_b;
    logic [1:0]  sel_a;
    logic [0:0]  sel_b;
    logic [27:0] hex_a;
    logic [13:0] hex_b;
    logic        ovf_a, ovf_b, done_a, done_b;

    always #5 clk = ~clk;

    dbg_display_mux u_dut_a (
        .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_prev(btn_prev),
        .ch_data(ch_a), .ch_sel(sel_a), .hex(hex_a), .ovf(ovf_a), .conv_done(done_a)
    );

    dbg_display_mux #(
        .N_CH(2), .IN_WIDTH(8), .N_DIG(2), .DEBOUNCE(4), .BLANK_LEADING(1'b0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .btn_next(btn_b_next), .btn_prev(btn_b_prev),
        .ch_data(ch_b), .ch_sel(sel_b), .hex(hex_b), .ovf(ovf_b), .conv_done(done_b)
    );

    typedef struct {
        int          cyc;
        logic [27:0] hex;
        logic        ovf;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   cyc;
    int   checks = 0;
    int   errors = 0;
    int   model_sel;

    // Decimal display model: plain arithmetic on the integer value
    function automatic void ref_disp(input int v, input int nd, input bit blank,
                                     output logic [27:0] h, output logic o);
        logic [6:0] pat [10];
        int pw;
        int dig;
        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
        pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
        pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
        pat[9] = 7'b0010000;
        h  = '0;
        pw = 1;
        for (int d = 0; d < nd; d++) pw = pw * 10;
        o  = (v >= pw);
        pw = 1;
        for (int d = 0; d < nd; d++) begin
            dig = (v / pw) % 10;
            if (o)                             h[d*7 +: 7] = 7'b0111111;
            else if (blank && d > 0 && v < pw) h[d*7 +: 7] = 7'b1111111;
            else                               h[d*7 +: 7] = pat[dig];
            pw = pw * 10;
        end
    endfunction

    task automatic chk(input string name, input logic [27:0] act, input logic [27:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Scoreboard producer: each conversion samples the selected channel at the
    // start of its period and shows it P cycles later
    initial begin
        exp_t e;
        cyc = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                cyc = 0;
                q_a.delete();
                q_b.delete();
            end else begin
                cyc++;
                if ((cyc - 1) % P_A == 0) begin
                    ref_disp(int'(ch_a[model_sel*6 +: 6]), 4, 1'b1, e.hex, e.ovf);
                    e.cyc = cyc + P_A - 1;
                    q_a.push_back(e);
                end
                if ((cyc - 1) % P_B == 0) begin
                    ref_disp(int'(ch_b[7:0]), 2, 1'b0, e.hex, e.ovf);
                    e.cyc = cyc + P_B - 1;
                    q_b.push_back(e);
                end
            end
        end
    end

    // Scoreboard consumer
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_a) begin
                if (q_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_done: got conv_done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = q_a.pop_front();
                    chk("a_done_cycle", 28'(cyc), 28'(e.cyc));
                    chk("a_hex", hex_a, e.hex);
                    chk("a_ovf", 28'(ovf_a), 28'(e.ovf));
                end
            end else if (q_a.size() > 0 && q_a[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL a_missing_done: got no conv_done expected at cycle %0d", q_a[0].cyc);
                e = q_a.pop_front();
            end
            if (done_b) begin
                if (q_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected_done: got conv_done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = q_b.pop_front();
                    chk("b_done_cycle", 28'(cyc), 28'(e.cyc));
                    chk("b_hex", 28'(hex_b), e.hex);
                    chk("b_ovf", 28'(ovf_b), 28'(e.ovf));
                end
            end else if (q_b.size() > 0 && q_b[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL b_missing_done: got no conv_done expected at cycle %0d", q_b[0].cyc);
                e = q_b.pop_front();
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        logic [27:0] h;
        logic        o;
        ref_disp(0, 4, 1'b1, h, o);
        chk({tag, "_a_sel"},  28'(sel_a), 28'(0));
        chk({tag, "_a_ovf"},  28'(ovf_a), 28'(0));
        chk({tag, "_a_done"}, 28'(done_a), 28'(0));
        chk({tag, "_a_hex"},  hex_a, h);
        ref_disp(0, 2, 1'b0, h, o);
        chk({tag, "_b_sel"},  28'(sel_b), 28'(0));
        chk({tag, "_b_ovf"},  28'(ovf_b), 28'(0));
        chk({tag, "_b_hex"},  28'(hex_b), h);
    endtask

    // Press buttons for len cycles, let them settle, then check the selection
    task automatic press(input logic nx, input logic pv, input int len, input int delta);
        btn_next = nx;
        btn_prev = pv;
        repeat (len) @(negedge clk);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (40) @(negedge clk);
        model_sel = (model_sel + delta + 4) % 4;
        chk("ch_sel", 28'(sel_a), 28'(model_sel));
    endtask

    function automatic logic [7:0] pick_b();
        case ($urandom_range(0, 5))
            0:       return 8'd99;
            1:       return 8'd100;
            2:       return 8'd150;
            3:       return 8'd255;
            4:       return 8'd5;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic [5:0] v;
        rst_n      = 1'b0;
        btn_next   = 1'b0;
        btn_prev   = 1'b0;
        btn_b_next = 1'b0;
        btn_b_prev = 1'b0;
        ch_a       = '0;
        ch_b       = '0;
        model_sel  = 0;

        repeat (3) @(negedge clk);
        chk_reset_state("reset");

        // First conversions: 47 on A, 150 (overflow) on B
        ch_a  = {6'd0, 6'd0, 6'd0, 6'd47};
        ch_b  = {8'd0, 8'd150};
        rst_n = 1'b1;
        repeat (2 * P_B) @(negedge clk);

        ch_a[5:0] = 6'd63; ch_b[7:0] = 8'd99;  repeat (2 * P_B) @(negedge clk);
        ch_a[5:0] = 6'd0;  ch_b[7:0] = 8'd100; repeat (2 * P_B) @(negedge clk);
        ch_a[5:0] = 6'd5;  ch_b[7:0] = 8'd5;   repeat (2 * P_B) @(negedge clk);

        // Random data, changed at arbitrary points in the conversion
        for (int i = 0; i < 30; i++) begin
            ch_a      = 24'($urandom);
            ch_b[7:0] = pick_b();
            ch_b[15:8] = 8'($urandom);
            repeat ($urandom_range(3, 15)) @(negedge clk);
        end

        // Channel selection with identical data on every channel
        v    = 6'($urandom);
        ch_a = {v, v, v, v};
        press(1'b1, 1'b0, 20, 1);    // 0 -> 1
        press(1'b0, 1'b1, 20, -1);   // 1 -> 0
        press(1'b0, 1'b1, 20, -1);   // 0 -> 3 wrap
        press(1'b1, 1'b0, 10, 0);    // short glitch ignored
        press(1'b1, 1'b1, 20, 0);    // both at once cancel
        press(1'b0, 1'b1, 10, 0);    // short glitch ignored
        press(1'b1, 1'b0, 20, 1);    // 3 -> 0 wrap

        // Channel switch 0 -> 1 landing mid-conversion: 12 then 35
        ch_a = {6'd7, 6'd20, 6'd35, 6'd12};
        repeat (2 * P_A) @(negedge clk);
        for (int k = 0; k < 2 * P_A && (cyc % P_A) != 2; k++) @(negedge clk);
        btn_next = 1'b1;
        repeat (20) @(negedge clk);
        btn_next  = 1'b0;
        model_sel = 1;
        repeat (40) @(negedge clk);
        chk("ch_sel_mid", 28'(sel_a), 28'(1));

        for (int i = 0; i < 20; i++) begin
            ch_a      = 24'($urandom);
            ch_b[7:0] = pick_b();
            repeat ($urandom_range(3, 15)) @(negedge clk);
        end

        // Reset during SHIFT restarts everything
        for (int k = 0; k < 2 * P_A && (cyc % P_A) != 3; k++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        model_sel = 0;
        chk_reset_state("midreset");
        ch_a[5:0] = 6'd9;
        ch_b[7:0] = 8'd42;
        rst_n = 1'b1;
        repeat (3 * P_B) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
